// File: rtl/rate_divisor_ctrl.sv
// rate_divisor_ctrl: pushbutton-driven saturating clock divisor with auto-repeat
// and a sample strobe that fires once every clk_divisor cycles.
module rate_divisor_ctrl #(
    parameter int          WIDTH         = 32,
    parameter int unsigned DEFAULT_DIV   = 6944,
    parameter int unsigned STEP          = 4,
    parameter int unsigned MIN_DIV       = 16,
    parameter int unsigned MAX_DIV       = 65535,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 2_500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             speedup,
    input  logic             speeddown,
    input  logic             restore,
    output logic [WIDTH-1:0] clk_divisor,
    output logic             tick,
    output logic             at_min,
    output logic             at_max
);
    localparam int WX = WIDTH + 1;
    localparam logic [WIDTH:0]   MIN_X  = WX'(MIN_DIV);
    localparam logic [WIDTH:0]   MAX_X  = WX'(MAX_DIV);
    localparam logic [WIDTH:0]   STEP_X = WX'(STEP);
    localparam logic [WIDTH-1:0] DEF    = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE    = 1;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;

    state_t           state;
    dir_t             dir, held;
    logic             su_q, sd_q, wrap;
    logic [31:0]      cnt;
    logic [WIDTH-1:0] tcnt, stepped;
    logic [WIDTH:0]   div_x, sum_x;

    // Step math is one bit wider than the divisor so saturation never sees a wrap.
    always_comb begin
        dir     = (su_q && !sd_q) ? UP : (sd_q && !su_q) ? DOWN : NONE;
        div_x   = {1'b0, clk_divisor};
        sum_x   = div_x + STEP_X;
        stepped = (dir == UP) ? WIDTH'((div_x < MIN_X + STEP_X) ? MIN_X : div_x - STEP_X)
                              : WIDTH'((sum_x > MAX_X) ? MAX_X : sum_x);
        wrap    = tcnt >= clk_divisor - ONE;
    end

    assign at_min = clk_divisor == WIDTH'(MIN_DIV);
    assign at_max = clk_divisor == WIDTH'(MAX_DIV);

    always_ff @(posedge clk) begin
        if (!reset) begin
            su_q        <= 1'b0;
            sd_q        <= 1'b0;
            state       <= IDLE;
            held        <= NONE;
            cnt         <= '0;
            clk_divisor <= DEF;
        end else begin
            su_q <= speedup;
            sd_q <= speeddown;
            if (restore) begin
                clk_divisor <= DEF;
                state       <= IDLE;
                cnt         <= '0;
            end else if (state == IDLE) begin
                if (dir != NONE) begin
                    clk_divisor <= stepped;
                    held        <= dir;
                    state       <= HOLD;
                    cnt         <= 32'(HOLD_CYCLES - 1);
                end
            end else if (dir != held) begin
                state <= IDLE;
            end else if (cnt == 32'd0) begin
                clk_divisor <= stepped;
                state       <= REPEAT;
                cnt         <= 32'(REPEAT_CYCLES - 1);
            end else begin
                cnt <= cnt - 32'd1;
            end
        end
    end

    // A count left above a freshly shrunk divisor wraps on the next edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            tcnt <= wrap ? '0 : tcnt + ONE;
        end
    end
endmodule

// File: tb/tb_rate_divisor_ctrl.sv
// tb_rate_divisor_ctrl: table-driven per-cycle divisor checks through a scoreboard
// queue, plus hand sequences for tick timing, restore and reset corner cases.
module tb_rate_divisor_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0, reset = 1'b0;
    logic         speedup = 1'b0, speeddown = 1'b0, restore = 1'b0;
    logic [W-1:0] clk_divisor;
    logic         tick, at_min, at_max;
    int           checks = 0, errors = 0, n;

    typedef struct {
        logic         su;
        logic         sd;
        logic         rs;
        logic [W-1:0] div;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    rate_divisor_ctrl #(
        .WIDTH(W), .DEFAULT_DIV(20), .STEP(4), .MIN_DIV(8), .MAX_DIV(32),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .speedup(speedup), .speeddown(speeddown),
        .restore(restore), .clk_divisor(clk_divisor), .tick(tick),
        .at_min(at_min), .at_max(at_max)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic su, input logic sd, input logic rs, input logic [W-1:0] div, input int cnt);
        repeat (cnt) vecs.push_back('{su, sd, rs, div});
    endtask

    task automatic drive(input logic su, input logic sd, input logic rs, input logic [W-1:0] div, input string name);
        logic [W-1:0] e;
        @(negedge clk);
        speedup   = su;
        speeddown = sd;
        restore   = rs;
        sb.push_back(div);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({name, " div"}, clk_divisor, e);
        check({name, " at_min"}, at_min, e == 8);
        check({name, " at_max"}, at_max, e == 32);
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!tick && cnt < 200);
    endtask

    initial begin
        // single presses
        add(1, 0, 0, 20, 1);  add(1, 0, 0, 16, 1);  add(0, 0, 0, 16, 3);
        add(0, 0, 1, 20, 1);  add(0, 0, 0, 20, 1);
        add(0, 1, 0, 20, 1);  add(0, 1, 0, 24, 1);  add(0, 0, 0, 24, 2);
        add(0, 0, 1, 20, 1);  add(0, 0, 0, 20, 1);
        // hold up to min, reverse mid-repeat, hold down to max
        add(1, 0, 0, 20, 1);  add(1, 0, 0, 16, 10); add(1, 0, 0, 12, 3);  add(1, 0, 0, 8, 6);
        add(0, 1, 0, 8, 2);   add(0, 1, 0, 12, 10); add(0, 1, 0, 16, 3);  add(0, 1, 0, 20, 3);
        add(0, 1, 0, 24, 3);  add(0, 1, 0, 28, 3);  add(0, 1, 0, 32, 9);
        // both buttons held
        add(0, 0, 1, 20, 1);  add(1, 1, 0, 20, 20); add(0, 0, 0, 20, 2);
        // restore while repeating at 12
        add(1, 0, 0, 20, 1);  add(1, 0, 0, 16, 10); add(1, 0, 0, 12, 2);
        add(1, 0, 1, 20, 1);  add(1, 0, 0, 16, 1);  add(0, 0, 0, 16, 2);

        repeat (3) @(posedge clk);
        #1;
        check("reset div", clk_divisor, 20);
        check("reset tick", tick, 0);
        check("reset at_min", at_min, 0);
        check("reset at_max", at_max, 0);
        @(negedge clk) reset = 1'b1;
        wait_tick(n);
        check("first tick", n, 20);
        wait_tick(n);
        check("tick period 20", n, 20);

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].su, vecs[i].sd, vecs[i].rs, vecs[i].div, $sformatf("vec%0d", i));

        @(negedge clk) speeddown = 1'b1;
        for (int i = 0; i < 100 && clk_divisor != 32; i++) begin
            @(posedge clk);
            #1;
        end
        check("reach max", clk_divisor, 32);
        @(negedge clk) speeddown = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold max div", clk_divisor, 32);
        check("hold max at_max", at_max, 1);
        wait_tick(n);
        check("tick seen at 32", tick, 1);
        wait_tick(n);
        check("tick period 32", n, 32);
        repeat (25) @(posedge clk);
        drive(0, 0, 1, 20, "shrink restore");
        check("shrink no tick yet", tick, 0);
        drive(0, 0, 0, 20, "shrink wrap");
        check("shrink wrap tick", tick, 1);
        wait_tick(n);
        check("tick period after shrink", n, 20);

        drive(1, 0, 0, 20, "rh sample");
        drive(1, 0, 0, 16, "rh step");
        drive(1, 0, 0, 16, "rh hold1");
        drive(1, 0, 0, 16, "rh hold2");
        reset = 1'b0;
        drive(1, 0, 0, 20, "reset in hold");
        reset = 1'b1;
        drive(1, 0, 0, 20, "post reset sample");
        drive(1, 0, 0, 16, "post reset step");
        drive(0, 0, 0, 16, "post reset hold");
        drive(0, 0, 0, 16, "post reset idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
